// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle control unit.
//   OP_*       : MIPS primary opcodes the controller understands
//   FUNCT_ADD  : R-type funct field for add
//   ALU_ADD/NOP: ALUcontrol encodings driven to the datapath ALU
//   state_t    : controller phase sequence
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_NOP = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK
  } state_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction handshake and datapath control bundle of mc_control_unit.
//   master : the controller (accepts InstrIn/InstrValid, drives everything else)
//   slave  : fetch source + datapath side
// With RETIRE_COUNT_EN defined the bundle also carries RetireCount and
// IllegalCount, CNT_W bits wide.
interface mc_control_unit_if
`ifdef RETIRE_COUNT_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ;
  logic [31:0] InstrIn;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Intruction;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic [3:0]  ALUcontrol;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic        Done;
  logic        Illegal;
`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] RetireCount;
  logic [CNT_W-1:0] IllegalCount;
`endif

  modport master (
    input  InstrIn, InstrValid,
    output InstrReady, Intruction, RegDst, RegWrite, ALUSrc, ALUcontrol,
           MemWrite, MemRead, MemToReg, Done, Illegal
`ifdef RETIRE_COUNT_EN
    , output RetireCount, IllegalCount
`endif
  );

  modport slave (
    output InstrIn, InstrValid,
    input  InstrReady, Intruction, RegDst, RegWrite, ALUSrc, ALUcontrol,
           MemWrite, MemRead, MemToReg, Done, Illegal
`ifdef RETIRE_COUNT_EN
    , input RetireCount, IllegalCount
`endif
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction-class decode from IR fields.
//   op, funct    : IR[31:26], IR[5:0]
//   rt, rd       : IR[20:16], IR[15:11]
//   is_*         : one-hot class of a supported instruction
//   illegal      : opcode/funct combination not supported
//   dest_is_zero : the register this instruction would write is $0
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic       is_add,
  output logic       is_addi,
  output logic       is_lw,
  output logic       is_sw,
  output logic       illegal,
  output logic       dest_is_zero
);

  always_comb begin
    is_add       = (op == OP_RTYPE) && (funct == FUNCT_ADD);
    is_addi      = (op == OP_ADDI);
    is_lw        = (op == OP_LW);
    is_sw        = (op == OP_SW);
    illegal      = !(is_add || is_addi || is_lw || is_sw);
    // R-type writes rd, I-type writes rt
    dest_is_zero = is_add ? (rd == 5'd0) : (rt == 5'd0);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the single-issue datapath.
// Accepts one instruction over InstrValid/InstrReady, latches it into IR and
// walks DECODE -> EXECUTE -> [MEM x MEM_LATENCY] -> WRITEBACK, pulsing Done on
// retirement or Illegal in DECODE for unsupported encodings.
//   Clk, Rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mc_control_unit_if.master (handshake + datapath controls)
// Parameters: MEM_LATENCY (1..15) cycles in MEM, CNT_W counter width.
// Optional macro RETIRE_COUNT_EN adds RetireCount / IllegalCount counters.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  mc_control_unit_if.master   bus
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mc_control_unit: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mc_control_unit: CNT_W must be at least 1");
  end

  localparam logic [3:0] MEM_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [3:0]  mem_cnt;
  logic        mem_last;

  logic is_add, is_addi, is_lw, is_sw, dec_illegal, dest_is_zero;

  logic       ready_st, regdst, regwrite, alusrc, memwrite, memread, memtoreg;
  logic       done, illegal;
  logic [3:0] aluctl;

  mc_decode u_decode (
    .op           (ir[31:26]),
    .funct        (ir[5:0]),
    .rt           (ir[20:16]),
    .rd           (ir[15:11]),
    .is_add       (is_add),
    .is_addi      (is_addi),
    .is_lw        (is_lw),
    .is_sw        (is_sw),
    .illegal      (dec_illegal),
    .dest_is_zero (dest_is_zero)
  );

  assign mem_last = (mem_cnt == 4'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      ir      <= '0;
      mem_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.InstrValid)
        ir <= bus.InstrIn;
      if (state == EXECUTE)
        mem_cnt <= MEM_LOAD;
      else if (state == MEM && !mem_last)
        mem_cnt <= mem_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.InstrValid) state_nxt = DECODE;
      DECODE:    state_nxt = dec_illegal ? IDLE : EXECUTE;
      EXECUTE:   state_nxt = (is_lw || is_sw) ? MEM : WRITEBACK;
      MEM:       if (mem_last) state_nxt = is_lw ? WRITEBACK : IDLE;
      WRITEBACK: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Moore outputs: state register and IR only
  always_comb begin
    ready_st = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    aluctl   = ALU_NOP;
    memwrite = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state)
      IDLE:    ready_st = 1'b1;
      DECODE:  illegal  = dec_illegal;
      EXECUTE: begin
        alusrc = is_addi || is_lw || is_sw;
        aluctl = ALU_ADD;
      end
      MEM: begin
        alusrc   = 1'b1;
        aluctl   = ALU_ADD;
        memread  = is_lw;
        memwrite = is_sw;
        done     = is_sw && mem_last;
      end
      WRITEBACK: begin
        regwrite = !dest_is_zero;
        regdst   = is_add;
        memtoreg = is_lw;
        alusrc   = is_addi || is_lw;
        aluctl   = ALU_ADD;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // IDLE is entered asynchronously on reset; gating keeps Ready low while held
  assign bus.InstrReady = ready_st && Rst_n;
  assign bus.Intruction = ir;
  assign bus.RegDst     = regdst;
  assign bus.RegWrite   = regwrite;
  assign bus.ALUSrc     = alusrc;
  assign bus.ALUcontrol = aluctl;
  assign bus.MemWrite   = memwrite;
  assign bus.MemRead    = memread;
  assign bus.MemToReg   = memtoreg;
  assign bus.Done       = done;
  assign bus.Illegal    = illegal;

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] retire_cnt, illegal_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      retire_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (done)    retire_cnt  <= retire_cnt + 1'b1;
      if (illegal) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign bus.RetireCount  = retire_cnt;
  assign bus.IllegalCount = illegal_cnt;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with a per-cycle expectation queue.
module tb_mc_control_unit;

  localparam int unsigned ML = 3;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;

`ifdef RETIRE_COUNT_EN
  mc_control_unit_if #(.CNT_W(CW)) bus ();
`else
  mc_control_unit_if bus ();
`endif

  mc_control_unit #(.MEM_LATENCY(ML), .CNT_W(CW)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ready;
    logic [31:0] ir;
    logic        regdst;
    logic        regwrite;
    logic        alusrc;
    logic [3:0]  alu;
    logic        memwrite;
    logic        memread;
    logic        memtoreg;
    logic        done;
    logic        illegal;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned exp_retire  = 0;
  int unsigned exp_illegal = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.ready    = bus.InstrReady;
    o.ir       = bus.Intruction;
    o.regdst   = bus.RegDst;
    o.regwrite = bus.RegWrite;
    o.alusrc   = bus.ALUSrc;
    o.alu      = bus.ALUcontrol;
    o.memwrite = bus.MemWrite;
    o.memread  = bus.MemRead;
    o.memtoreg = bus.MemToReg;
    o.done     = bus.Done;
    o.illegal  = bus.Illegal;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = observe();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Reference model: one entry per cycle from DECODE to the IDLE cycle after retire
  task automatic push_model(input logic [31:0] instr);
    obs_t b, e;
    logic [5:0] op, fn;
    logic add, addi, lw, sw, ill, dz;
    op   = instr[31:26];
    fn   = instr[5:0];
    add  = (op == 6'h00) && (fn == 6'h20);
    addi = (op == 6'h08);
    lw   = (op == 6'h23);
    sw   = (op == 6'h2B);
    ill  = !(add || addi || lw || sw);
    dz   = add ? (instr[15:11] == 5'd0) : (instr[20:16] == 5'd0);
    b    = '0;
    b.ir = instr;
    e = b; e.illegal = ill;
    exp_q.push_back(e);
    if (!ill) begin
      e = b; e.alu = 4'b0101; e.alusrc = !add;
      exp_q.push_back(e);
      if (lw || sw) begin
        for (int unsigned k = 0; k < ML; k++) begin
          e = b; e.alu = 4'b0101; e.alusrc = 1'b1;
          e.memread = lw; e.memwrite = sw; e.done = sw && (k == ML - 1);
          exp_q.push_back(e);
        end
      end
      if (!sw) begin
        e = b; e.alu = 4'b0101; e.alusrc = !add; e.regwrite = !dz;
        e.regdst = add; e.memtoreg = lw; e.done = 1'b1;
        exp_q.push_back(e);
      end
    end
    e = b; e.ready = 1'b1;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; InstrValid stays high with a junk
  // word while busy to confirm it is ignored, dropped on the Done/Illegal cycle.
  task automatic run_instr(input logic [31:0] instr, input string tag);
    obs_t e;
    push_model(instr);
    bus.InstrIn    = instr;
    bus.InstrValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.InstrIn = ~instr;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, e);
      if (e.done)    exp_retire++;
      if (e.illegal) exp_illegal++;
      if (e.done || e.illegal) bus.InstrValid = 1'b0;
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef RETIRE_COUNT_EN
    check_val({tag, "_retire"}, 32'(bus.RetireCount), 32'(CW'(exp_retire)));
    check_val({tag, "_illegal"}, 32'(bus.IllegalCount), 32'(CW'(exp_illegal)));
`else
    check_val({tag, "_nocnt"}, 32'(exp_q.size()), 32'd0);
`endif
  endtask

  initial begin
    obs_t e;
    rst_n          = 1'b0;
    bus.InstrIn    = '0;
    bus.InstrValid = 1'b0;
    #1;
    check("reset", '0);
    check_counters("reset_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    e = '0; e.ready = 1'b1;
    check("post_reset_idle", e);
    @(negedge clk);

    run_instr(32'h00221820, "add_r3");
    run_instr(32'h8C040008, "lw_r4");
    run_instr(32'hAC220004, "sw_r2");
    run_instr(32'hFC000000, "illegal_op");
    run_instr(32'h20000005, "addi_r0");
    run_instr(32'h00221822, "illegal_funct");
    run_instr(32'h20250007, "addi_r5");
    check_counters("cnt_mix");

    // lw aborted by reset in its 2nd MEM cycle
    push_model(32'h8C040008);
    bus.InstrIn    = 32'h8C040008;
    bus.InstrValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.InstrValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      check("lw_abort_pre", e);
      if (k < 2) @(negedge clk);
    end
    @(posedge clk);
    #2;
    e = exp_q.pop_front();
    check("lw_abort_mem2", e);
    rst_n = 1'b0;
    #1;
    check("lw_abort_async", '0);
    exp_q.delete();
    exp_retire  = 0;
    exp_illegal = 0;
    check_counters("abort_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    e = '0; e.ready = 1'b1;
    check("abort_release", e);
    @(negedge clk);
    run_instr(32'h20250007, "addi_after_abort");

`ifdef RETIRE_COUNT_EN
    rst_n = 1'b0;
    exp_retire  = 0;
    exp_illegal = 0;
    #1;
    check_counters("cnt_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 17; n++) run_instr(32'h20250007, "addi_burst");
    check_counters("cnt_wrap");
    run_instr(32'hFC000000, "cnt_illegal");
    check_counters("cnt_illegal_one");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control FSM that sequences the Data_Path single-issue datapath: register file, ALU, data memory and write-back muxes.
- Accepts one 32-bit MIPS instruction at a time over a valid/ready handshake and latches it into an instruction register (IR).
- Drives the IR plus every datapath control line phase by phase: DECODE, EXECUTE, MEM, WRITEBACK.
- Reports completion (Done) or rejection (Illegal).

Parameters:
- MEM_LATENCY, 1, cycles the MEM state holds MemRead/MemWrite (legal range 1..15).
- CNT_W, 16, width of the optional retire counter.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- InstrIn  in  32  instruction offered by the fetch source.
- InstrValid  in  1  InstrIn is valid.
- InstrReady  out  1  controller can accept an instruction.
- Intruction  out  32  IR contents, feeds the datapath instruction port.
- RegDst  out  1  1 selects rd [15:11]; 0 selects rt [20:16].
- RegWrite  out  1  register-file write enable.
- ALUSrc  out  1  1 selects sign-extended imm; 0 selects RD2.
- ALUcontrol  out  4  ALU operation code.
- MemWrite  out  1  data-memory write enable.
- MemRead  out  1  data-memory read enable.
- MemToReg  out  1  1 writes back memory data; 0 writes back ALU result.
- Done  out  1  1-cycle pulse, instruction retired.
- Illegal  out  1  1-cycle pulse, opcode/funct not supported.

Behaviour:
- Reset is asynchronous and active-low (Rst_n): single clock Clk; asserting Rst_n=0 forces the FSM to IDLE immediately.
- Values while Rst_n=0: IR=0; all control outputs, Done and Illegal = 0; InstrReady=0.
- Supported instructions:
  - R-type add: op 0x00, funct 0x20.
  - addi: op 0x08.
  - lw: op 0x23.
  - sw: op 0x2B.
- ALUcontrol = ALU_ADD (4'b0101) for all supported instructions; 4'b0000 in any state where no ALU op is issued.
- Outputs are Moore-style: decoded from the state register and IR only, with no combinational path from InstrIn or InstrValid.
- IDLE:
  - InstrReady=1.
  - When InstrValid=1 at a rising edge: IR<=InstrIn, go to DECODE.
- DECODE (1 cycle): IR is presented so the register file latches rs/rt.
  - Unsupported op, or op 0 with funct != 0x20: Illegal=1 during this cycle, next state IDLE, no RegWrite/MemWrite ever asserted.
  - Otherwise next state EXECUTE.
- EXECUTE (1 cycle):
  - ALUSrc=1 for addi/lw/sw; 0 for add.
  - Next state: MEM for lw/sw; WRITEBACK for add/addi.
- MEM (MEM_LATENCY cycles, down-counter loaded on entry):
  - ALUSrc=1 held; MemRead=1 for lw, MemWrite=1 for sw, both held for the full count.
  - When the count expires: lw goes to WRITEBACK; sw asserts Done on its last MEM cycle and goes to IDLE.
- WRITEBACK (1 cycle):
  - RegWrite=1; RegDst=1 for add, 0 otherwise; MemToReg=1 for lw only; ALUSrc held as in EXECUTE.
  - Done=1; next state IDLE.
- Write to $0: when the destination register index = 0, RegWrite is suppressed (held 0) but Done still pulses.
- Latency from the acceptance edge to the Done cycle:
  - add/addi: 3 cycles.
  - sw: 2+MEM_LATENCY cycles.
  - lw: 3+MEM_LATENCY cycles.
- Throughput: the next instruction is accepted no earlier than the edge ending the Done cycle.
- InstrValid while InstrReady=0 is ignored; the source must hold it.
- Rst_n asserted mid-instruction: the instruction is abandoned and any write strobe in flight drops asynchronously.
- MEM_LATENCY out of range: elaboration-time $error.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- When defined:
  - Extra output RetireCount [CNT_W-1:0], reset to 0, incremented on every Done pulse, wraps to 0 after all-ones.
  - Extra output IllegalCount [CNT_W-1:0] with the same rules, driven by Illegal.
- When undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW;
  - FUNCT_ADD;
  - ALU_ADD = 4'b0101 and ALU_NOP = 4'b0000;
  - state enum (IDLE, DECODE, EXECUTE, MEM, WRITEBACK).
- One sub-module, mc_decode: combinational IR-to-class decode (is_add, is_addi, is_lw, is_sw, illegal, dest_is_zero).

Test Plan:
- add $3,$1,$2 (0x00221820), MEM_LATENCY=1 -> Illegal=0; RegWrite=1, RegDst=1, MemToReg=0, ALUcontrol=0101 on cycle 3 together with Done; no MemRead/MemWrite.
- lw $4,8($0) (0x8C040008), MEM_LATENCY=3 -> MemRead=1 for exactly 3 cycles with ALUSrc=1; then RegWrite=1, MemToReg=1, RegDst=0; Done on cycle 6.
- sw $2,4($1) (0xAC220004) -> MemWrite=1 for 1 cycle; Done in the same cycle; RegWrite never asserted; InstrReady back to 1 the next cycle.
- Illegal and $0 destination: 0xFC000000 -> Illegal pulse in DECODE, no write strobes, back to IDLE. Then addi $0,$0,5 (0x20000005) -> Done pulses, RegWrite stays 0.
- Reset during MEM of lw (MEM_LATENCY=4, Rst_n low in the 2nd MEM cycle) -> MemRead drops without waiting for Clk; InstrReady=1 after release; a following addi $5,$1,7 (0x20250007) completes normally.
- RETIRE_COUNT_EN with CNT_W=4: 17 back-to-back addi -> RetireCount=1; one illegal instruction -> IllegalCount=1.
